// File: rtl/tawas_rcn_sram.sv
// tawas_rcn_sram: RCN ring slave terminating windowed requests on a single-port synchronous SRAM
module tawas_rcn_sram #(
  parameter logic [23:0] ADDR_BASE = 24'h000000,
  parameter logic [23:0] ADDR_MASK = 24'hFFF000,
  parameter int SRAM_AW = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [68:0]        rcn_in,
  output logic [68:0]        rcn_out,
  output logic               mem_cs,
  output logic               mem_wr,
  output logic [SRAM_AW-1:0] mem_addr,
  output logic [3:0]         mem_mask,
  output logic [31:0]        mem_wdata,
  input  logic [31:0]        mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

  state_t      state;
  logic [68:0] pkt;
  logic [3:0]  cnt;
  logic        match;

  assign match = rcn_in[68] & rcn_in[67] & ((rcn_in[55:32] & ADDR_MASK) == ADDR_BASE);

  // Accept one request, run the SRAM access, then inject the response into the first empty slot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      pkt       <= '0;
      cnt       <= '0;
      rcn_out   <= '0;
      mem_cs    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_mask  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (match) begin
            pkt       <= rcn_in;
            rcn_out   <= '0;
            mem_cs    <= 1'b1;
            mem_wr    <= rcn_in[66];
            mem_addr  <= rcn_in[32 +: SRAM_AW];
            mem_mask  <= rcn_in[59:56];
            mem_wdata <= rcn_in[31:0];
            state     <= S_ACCESS;
          end else begin
            rcn_out <= rcn_in;
          end
        end
        S_ACCESS: begin
          rcn_out      <= rcn_in;
          mem_cs       <= 1'b0;
          cnt          <= 4'(WAIT_STATES);
          pkt[67]      <= 1'b0;
          pkt[31:0]    <= 32'h0;
          state        <= pkt[66] ? S_RESP : S_WAIT;
        end
        S_WAIT: begin
          rcn_out <= rcn_in;
          if (cnt == 4'd0) begin
            pkt[31:0] <= mem_rdata;
            state     <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          rcn_out <= rcn_in[68] ? rcn_in : pkt;
          state   <= rcn_in[68] ? S_RESP : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tawas_rcn_sram.sv
// tb_tawas_rcn_sram: randomized and directed checks of the RCN SRAM slave against a transaction-level model
module tb_tawas_rcn_sram;
  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [68:0] rcn_in = '0;
  logic [68:0] rcn_out;
  logic        mem_cs, mem_wr;
  logic [11:0] mem_addr;
  logic [3:0]  mem_mask;
  logic [31:0] mem_wdata, mem_rdata;

  int checks = 0;
  int failures = 0;

  tawas_rcn_sram #(.ADDR_BASE(24'h000000), .ADDR_MASK(24'hFFF000), .SRAM_AW(12), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst(rst), .rcn_in(rcn_in), .rcn_out(rcn_out),
    .mem_cs(mem_cs), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_mask(mem_mask),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // SRAM environment: byte-masked writes, reads delivered 1+WS cycles after the strobe
  logic [31:0] sram [0:4095];
  logic [31:0] pipe [0:WS];
  logic [31:0] w;
  always @(posedge clk) begin
    if (mem_cs && mem_wr) begin
      w = sram[mem_addr];
      for (int b = 0; b < 4; b++) if (mem_mask[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
      sram[mem_addr] <= w;
    end
    pipe[0] <= (mem_cs && !mem_wr) ? sram[mem_addr] : $urandom;
    for (int i = 1; i <= WS; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[WS];

  // Reference model: one outstanding transaction, response ready a fixed time after accept
  logic [31:0] ref_mem [0:4095];
  bit          busy = 0;
  int          ready = 0;
  int          cyc = 0;
  logic [68:0] resp;

  task automatic chk(input string tag, input logic [68:0] obs, input logic [68:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_match(input logic [68:0] p);
    return p[68] && p[67] && ((p[55:32] & 24'hFFF000) == 24'h0);
  endfunction

  task automatic step(input logic [68:0] p);
    logic [68:0] e_out;
    bit          e_cs;
    logic [11:0] a;
    logic [31:0] m;
    rcn_in = p;
    e_cs = 0;
    a = p[43:32];
    if (!busy && is_match(p)) begin
      e_out = '0;
      e_cs  = 1;
      busy  = 1;
      ready = cyc + (p[66] ? 2 : 3 + WS);
      resp  = {1'b1, 1'b0, p[66:32], p[66] ? 32'h0 : ref_mem[a]};
      if (p[66]) begin
        m = ref_mem[a];
        for (int b = 0; b < 4; b++) if (p[56+b]) m[8*b +: 8] = p[8*b +: 8];
        ref_mem[a] = m;
      end
    end else if (busy && cyc >= ready && !p[68]) begin
      e_out = resp;
      busy  = 0;
    end else begin
      e_out = p;
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("rcn_out", rcn_out, e_out);
    chk("mem_cs", 69'(mem_cs), 69'(e_cs));
    if (e_cs) begin
      chk("mem_wr", 69'(mem_wr), 69'(p[66]));
      chk("mem_addr", 69'(mem_addr), 69'(a));
      chk("mem_mask", 69'(mem_mask), 69'(p[59:56]));
      if (p[66]) chk("mem_wdata", 69'(mem_wdata), 69'(p[31:0]));
    end
  endtask

  function automatic logic [68:0] mk(input bit req, input bit wr, input logic [5:0] id,
                                     input logic [3:0] mask, input logic [23:0] addr, input logic [31:0] data);
    return {1'b1, req, wr, id, mask, addr, data};
  endfunction

  initial begin
    logic [68:0] p;
    logic [11:0] hi;
    int r;
    for (int i = 0; i < 4096; i++) begin
      sram[i] = '0;
      ref_mem[i] = '0;
    end
    #2 rst = 1'b0;
    // Reset held with traffic toggling
    for (int i = 0; i < 4; i++) begin
      rcn_in = {1'b1, 68'($urandom), 4'h0, 24'h000010, 32'($urandom)};
      @(posedge clk);
      #1;
      chk("rst_rcn_out", rcn_out, '0);
      chk("rst_mem_cs", 69'(mem_cs), 69'(0));
      chk("rst_mem_wr", 69'(mem_wr), 69'(0));
      chk("rst_mem_addr", 69'(mem_addr), 69'(0));
      chk("rst_mem_mask", 69'(mem_mask), 69'(0));
      chk("rst_mem_wdata", 69'(mem_wdata), 69'(0));
    end
    rst = 1'b1;
    step(mk(1, 0, 6'd9, 4'h3, 24'h004321, 32'h01234567));
    step('0);
    // Write then ack on an empty ring
    step(mk(1, 1, 6'd5, 4'hF, 24'h000010, 32'hDEADBEEF));
    chk("wr_cs", 69'(mem_cs), 69'(1));
    chk("wr_addr", 69'(mem_addr), 69'(12'h010));
    step('0);
    step('0);
    chk("wr_ack", rcn_out, mk(0, 1, 6'd5, 4'hF, 24'h000010, 32'h0));
    // Read back with wait states
    step(mk(1, 0, 6'd5, 4'hF, 24'h000010, 32'h0));
    for (int i = 0; i < 5; i++) step('0);
    chk("rd_resp", rcn_out, mk(0, 0, 6'd5, 4'hF, 24'h000010, 32'hDEADBEEF));
    // Second request while busy is forwarded, then retried
    step(mk(1, 0, 6'd1, 4'hF, 24'h000010, 32'h0));
    step('0);
    step(mk(1, 1, 6'd2, 4'h3, 24'h000020, 32'h12345678));
    for (int i = 0; i < 8; i++) step('0);
    step(mk(1, 1, 6'd2, 4'h3, 24'h000020, 32'h12345678));
    for (int i = 0; i < 3; i++) step('0);
    step(mk(1, 0, 6'd3, 4'hF, 24'h000020, 32'h0));
    for (int i = 0; i < 5; i++) step('0);
    chk("retry_rd", rcn_out, mk(0, 0, 6'd3, 4'hF, 24'h000020, 32'h00005678));
    // Ring fully occupied while response pending
    step(mk(1, 1, 6'd7, 4'h0, 24'h000040, 32'hFFFFFFFF));
    for (int i = 0; i < 10; i++) step(mk(0, $urandom_range(0, 1), 6'($urandom), 4'($urandom), 24'($urandom), 32'($urandom)));
    step('0);
    chk("busy_ring_ack", rcn_out, mk(0, 1, 6'd7, 4'h0, 24'h000040, 32'h0));
    // Out-of-window request
    step(mk(1, 1, 6'd4, 4'hF, 24'h001000, 32'hCAFEF00D));
    chk("oow_cs", 69'(mem_cs), 69'(0));
    for (int i = 0; i < 6; i++) step('0);
    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      hi = 12'($urandom_range(1, 4095));
      if (r < 3) p = '0;
      else if (r < 6) p = mk(1, $urandom_range(0, 1), 6'($urandom), 4'($urandom), {12'h0, 12'($urandom_range(0, 31))}, 32'($urandom));
      else if (r < 8) p = mk(1, $urandom_range(0, 1), 6'($urandom), 4'($urandom), {hi, 12'($urandom)}, 32'($urandom));
      else if (r < 9) p = mk(0, $urandom_range(0, 1), 6'($urandom), 4'($urandom), {12'h0, 12'($urandom)}, 32'($urandom));
      else p = {1'b1, 68'($urandom)};
      step(p);
    end
    for (int i = 0; i < 20; i++) step('0);
    // Reset in the middle of a read discards it
    step(mk(1, 0, 6'd6, 4'hF, 24'h000010, 32'h0));
    step('0);
    step('0);
    rst = 1'b0;
    #1;
    chk("midrst_out", rcn_out, '0);
    chk("midrst_cs", 69'(mem_cs), 69'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    busy = 0;
    for (int i = 0; i < 8; i++) step('0);
    step(mk(1, 0, 6'd8, 4'hF, 24'h000010, 32'h0));
    for (int i = 0; i < 8; i++) step('0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
